// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline <-> hazard controller signal bundle
interface hazard_ctrl_if #(parameter int CNT_W = 16);
  logic [31:0]      ir1;
  logic [4:0]       rd2;
  logic             reg_wr1;
  logic             rd_en1;
  logic             wr_en1;
  logic             mem_ready;
  logic             br_taken;
  logic             dbg_halt_req;
  logic             dbg_resume;
  logic             sel_pA;
  logic             sel_pB;
  logic             stall;
  logic             flush;
  logic [1:0]       state;
  logic             dbg_halted;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output ir1, rd2, reg_wr1, rd_en1, wr_en1, mem_ready, br_taken,
           dbg_halt_req, dbg_resume,
    input  sel_pA, sel_pB, stall, flush, state, dbg_halted, mem_err,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  ir1, rd2, reg_wr1, rd_en1, wr_en1, mem_ready, br_taken,
           dbg_halt_req, dbg_resume,
    output sel_pA, sel_pB, stall, flush, state, dbg_halted, mem_err,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - forwarding, stall/flush, debug halt and memory-timeout FSM
// Optional stall/flush performance counters are enabled by defining HAZ_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input logic         clk,
  input logic         reset,
  hazard_ctrl_if.slave bus
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALTED   = 2'd2,
    FAULT    = 2'd3
  } state_t;

  state_t          cur_state, nxt_state;
  logic [WW-1:0]   wait_cnt, wait_nxt;
  logic            mem_busy;
  logic            stall_c, flush_c;
  logic            unused_ir;

  assign unused_ir = ^{bus.ir1[31:25], bus.ir1[14:0]};

  assign bus.sel_pA = bus.reg_wr1 && (bus.rd2 != 5'd0) && (bus.rd2 == bus.ir1[19:15]);
  assign bus.sel_pB = bus.reg_wr1 && (bus.rd2 != 5'd0) && (bus.rd2 == bus.ir1[24:20]);

  assign mem_busy = (bus.rd_en1 | bus.wr_en1) && !bus.mem_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_state <= RUN;
      wait_cnt  <= '0;
    end else begin
      cur_state <= nxt_state;
      wait_cnt  <= wait_nxt;
    end
  end

  always_comb begin
    nxt_state = cur_state;
    wait_nxt  = wait_cnt;
    stall_c   = 1'b0;
    flush_c   = 1'b0;
    case (cur_state)
      RUN: begin
        stall_c = mem_busy;
        flush_c = bus.br_taken && !mem_busy;
        if (mem_busy)              nxt_state = MEM_WAIT;
        else if (bus.dbg_halt_req) nxt_state = HALTED;
      end
      MEM_WAIT: begin
        // Release the pipeline in the completion cycle; branches stay suppressed
        // and are re-evaluated from the held IR1 once back in RUN.
        stall_c = !bus.mem_ready;
        if (bus.mem_ready) begin
          wait_nxt  = '0;
          nxt_state = bus.dbg_halt_req ? HALTED : RUN;
        end else begin
          wait_nxt = wait_cnt + 1'b1;
          if (wait_cnt == WAIT_LAST) nxt_state = FAULT;
        end
      end
      HALTED: begin
        stall_c = 1'b1;
        if (bus.dbg_resume && !bus.dbg_halt_req) nxt_state = RUN;
      end
      FAULT: begin
        stall_c = 1'b1;
      end
      default: nxt_state = RUN;
    endcase
  end

  assign bus.stall      = stall_c;
  assign bus.flush      = flush_c;
  assign bus.state      = cur_state;
  assign bus.dbg_halted = (cur_state == HALTED);
  assign bus.mem_err    = (cur_state == FAULT);

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_c && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
      if (flush_c && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign bus.stall_cnt = stall_cnt;
  assign bus.flush_cnt = flush_cnt;
`else
  assign bus.stall_cnt = '0;
  assign bus.flush_cnt = '0;
`endif
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 15, maximum MEM_WAIT cycles before fault.
REQ-002 Parameter: CNT_W, default 16, width of performance counters.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 ir1  in  32  instruction in execute stage.
REQ-006 rd2  in  5  destination register of writeback-stage instruction.
REQ-007 reg_wr1  in  1  writeback-stage register write enable.
REQ-008 rd_en1, wr_en1  in  1 each  writeback-stage data-memory read/write.
REQ-009 mem_ready  in  1  data memory has completed current access.
REQ-010 br_taken  in  1  branch/jump resolved taken in execute.
REQ-011 dbg_halt_req, dbg_resume  in  1 each  debug halt/resume requests.
REQ-012 sel_pA, sel_pB  out  1 each  forward writeback data to operand A/B.
REQ-013 stall  out  1  hold PC, IR1, and all stage-2 pipeline registers.
REQ-014 flush  out  1  select NOP (32'h00000013) into IR1.
REQ-015 state  out  2  FSM state: RUN=0, MEM_WAIT=1, HALTED=2, FAULT=3.
REQ-016 dbg_halted  out  1  high only in HALTED.
REQ-017 mem_err  out  1  sticky timeout flag.
REQ-018 stall_cnt, flush_cnt  out  CNT_W each  performance counters.

Function
REQ-019 sel_pA SHALL = reg_wr1 && rd2!=0 && rd2==ir1[19:15]; sel_pB likewise with ir1[24:20]; combinational, valid in every state.
REQ-020 mem_busy SHALL = (rd_en1 | wr_en1) && !mem_ready.
REQ-021 RUN: stall = mem_busy; flush = br_taken && !mem_busy.
REQ-022 RUN -> MEM_WAIT when mem_busy; else RUN -> HALTED when dbg_halt_req; else stay.
REQ-023 MEM_WAIT: stall=1, flush=0; wait counter increments each cycle in MEM_WAIT.
REQ-024 MEM_WAIT exit when mem_ready=1: stall deasserts that same cycle; next state HALTED if dbg_halt_req, else RUN; wait counter clears.
REQ-025 Branch during MEM_WAIT SHALL be suppressed; since IR1 is held, it is re-evaluated in the RUN cycle after release.
REQ-026 Wait counter reaching MEM_TIMEOUT with mem_ready=0 -> FAULT; mem_ready arriving in the same cycle takes priority (normal exit).
REQ-027 FAULT: stall=1, flush=0, mem_err=1; exit only by reset.
REQ-028 HALTED: stall=1, flush=0, dbg_halted=1; -> RUN when dbg_resume && !dbg_halt_req.
REQ-029 RUN with br_taken and dbg_halt_req together: flush asserted that cycle, then HALTED.
REQ-030 Wait counter width SHALL be clog2(MEM_TIMEOUT+1); no wrap possible.

Reset
REQ-031 While reset=0: state=RUN, wait counter=0, mem_err=0, dbg_halted=0, counters=0; stall and flush follow REQ-021 from inputs.
REQ-032 Reset asserted mid-MEM_WAIT, HALTED, or FAULT SHALL force RUN immediately, asynchronously.

Configuration
REQ-033 Macro HAZ_PERF_CNT_EN defined: stall_cnt increments each cycle stall=1, flush_cnt each cycle flush=1, both saturating at all-ones.
REQ-034 Macro undefined: stall_cnt and flush_cnt tied to 0, no counter flops.

Verification
REQ-035 reg_wr1=1, rd2=5, ir1 rs1=5, rs2=5 -> sel_pA=1, sel_pB=1; rd2=0 -> both 0.
REQ-036 rd_en1=1, mem_ready=0 for 3 cycles then 1 -> stall=1 for 3 cycles, state=1 for 3 cycles, then RUN; with macro, stall_cnt=3.
REQ-037 br_taken=1 during MEM_WAIT -> flush=0; br_taken held through release -> flush=1 in the first RUN cycle.
REQ-038 wr_en1=1, mem_ready=0 held 16 cycles, MEM_TIMEOUT=15 -> state=3, mem_err=1, stall=1 until reset; reset=0 -> RUN, mem_err=0.
REQ-039 dbg_halt_req pulsed during MEM_WAIT, held until mem_ready -> direct MEM_WAIT->HALTED, dbg_halted=1; dbg_resume=1 with halt_req=0 -> RUN next cycle.
REQ-040 Macro defined, CNT_W=4, 20 consecutive flush cycles -> flush_cnt=15 (saturated).
